// File: rtl/shiftin.sv
// ---------------------------------------------------------------------------
// shiftin -- serial-to-parallel receiver for a clock/data/latch stream.
//
// The three serial lines are asynchronous to clk_in. Each line is resynchronised
// through two flops. The clock and latch lines also get a history flop, which is
// used to find their rising edges. Each serial-clock edge shifts one data bit
// into r_sr. A latch edge ends the frame: if exactly WIDTH bits arrived, the word
// is published with a one-cycle valid strobe; otherwise a one-cycle error strobe
// is raised and word_out keeps its previous value.
//
// Ports:
//   clk_in        system clock, rising edge
//   reset_in      synchronous, active-high reset
//   ser_clk_in    serial shift clock (async)
//   ser_data_in   serial data, stable around rising ser_clk_in
//   ser_latch_in  frame latch, rising edge ends a frame
//   word_out      last correctly received word
//   valid_out     one-cycle pulse when word_out updates
//   error_out     one-cycle pulse on a latch with bit count != WIDTH
//   debug_out     high while a frame is in progress (bit count > 0)
// ---------------------------------------------------------------------------
module shiftin #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             ser_clk_in,
    input  logic             ser_data_in,
    input  logic             ser_latch_in,
    output logic [WIDTH-1:0] word_out,
    output logic             valid_out,
    output logic             error_out,
    output logic             debug_out
);

    localparam int CW = $clog2(WIDTH) + 2;
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_OVER = CW'(WIDTH + 1);

    // Frame state is a pure function of the bit count.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SHIFTING = 2'd1,
        S_FULL     = 2'd2,
        S_OVER     = 2'd3
    } state_t;

    // Synchronisers and edge history
    logic r_clk_s1, r_clk_s2, r_clk_h;
    logic r_dat_s1, r_dat_s2;
    logic r_lat_s1, r_lat_s2, r_lat_h;

    // Frame datapath
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_word;
    logic             r_valid;
    logic             r_error;
    logic             r_debug;

    logic             w_clk_edge;
    logic             w_lat_edge;
    logic [WIDTH-1:0] w_sr_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    state_t           w_state_nxt;

    assign w_clk_edge = r_clk_s2 & ~r_clk_h;
    assign w_lat_edge = r_lat_s2 & ~r_lat_h;

    // The clock edge is applied first. A latch in the same cycle then sees the
    // updated shift register and count.
    always_comb begin
        w_sr_nxt  = r_sr;
        w_cnt_nxt = r_cnt;
        if (w_clk_edge) begin
            // r_dat_s2 has the same sync depth as r_clk_s2, so it holds the bit
            // that was present at the serial clock rise.
            if (MSB_FIRST) begin
                w_sr_nxt = {r_sr[WIDTH-2:0], r_dat_s2};
            end else begin
                w_sr_nxt = {r_dat_s2, r_sr[WIDTH-1:1]};
            end
            // The count saturates at WIDTH+1 ("over"). The data keeps shifting.
            if (r_cnt != CNT_OVER) begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end
    end

    // Frame state after any clock edge in this cycle. A latch uses this state.
    always_comb begin
        w_state_nxt = S_IDLE;
        if (w_cnt_nxt == CNT_OVER) begin
            w_state_nxt = S_OVER;
        end else if (w_cnt_nxt == CNT_FULL) begin
            w_state_nxt = S_FULL;
        end else if (w_cnt_nxt != '0) begin
            w_state_nxt = S_SHIFTING;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_clk_s1 <= 1'b0;
            r_clk_s2 <= 1'b0;
            r_clk_h  <= 1'b0;
            r_dat_s1 <= 1'b0;
            r_dat_s2 <= 1'b0;
            r_lat_s1 <= 1'b0;
            r_lat_s2 <= 1'b0;
            r_lat_h  <= 1'b0;
            r_sr     <= '0;
            r_cnt    <= '0;
            r_word   <= '0;
            r_valid  <= 1'b0;
            r_error  <= 1'b0;
            r_debug  <= 1'b0;
        end else begin
            r_clk_s1 <= ser_clk_in;
            r_clk_s2 <= r_clk_s1;
            r_clk_h  <= r_clk_s2;
            r_dat_s1 <= ser_data_in;
            r_dat_s2 <= r_dat_s1;
            r_lat_s1 <= ser_latch_in;
            r_lat_s2 <= r_lat_s1;
            r_lat_h  <= r_lat_s2;

            r_sr    <= w_sr_nxt;
            r_valid <= 1'b0;
            r_error <= 1'b0;

            if (w_lat_edge) begin
                r_cnt   <= '0;
                r_debug <= 1'b0;
                if (w_state_nxt == S_FULL) begin
                    r_word  <= w_sr_nxt;
                    r_valid <= 1'b1;
                end else begin
                    r_error <= 1'b1;
                end
            end else begin
                r_cnt   <= w_cnt_nxt;
                r_debug <= (w_cnt_nxt != '0);
            end
        end
    end

    assign word_out  = r_word;
    assign valid_out = r_valid;
    assign error_out = r_error;
    assign debug_out = r_debug;

endmodule
